// File: rtl/ram_prg.sv
// Parametrised bus-attached RAM with integrated MAR, optional clear-on-reset
// sweep and a valid/ready programming loader with an auto-incrementing pointer.
module ram_prg #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 4,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] bus,
  input  logic              mar_in,
  input  logic              wr_en,
  input  logic              re_en,
  input  logic              prg_mode,
  input  logic              prg_valid,
  input  logic [DATA_W-1:0] prg_data,
  output logic              prg_ready,
  output logic [ADDR_W-1:0] prg_addr,
  output logic              prg_done,
  output logic              busy,
  output logic [ADDR_W-1:0] mar
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_RUN,
    S_PROGRAM,
    S_DONE
  } state_t;

  state_t state, state_d;

  logic [ADDR_W-1:0] mar_d, prg_addr_d;
  logic              ready_d, done_d, busy_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Zero power-up image; the array itself is never reset.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  // The read path is combinational so a word lands on the bus in the same
  // cycle re_en is raised.
  assign bus = (state == S_RUN && re_en) ? mem[mar] : {DATA_W{1'bz}};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state;
    mar_d      = mar;
    prg_addr_d = prg_addr;
    ready_d    = prg_ready;
    done_d     = prg_done;
    busy_d     = busy;
    mem_we     = 1'b0;
    mem_waddr  = prg_addr;
    mem_wdata  = '0;

    unique case (state)
      S_CLEAR: begin
        mem_we     = 1'b1;
        prg_addr_d = prg_addr + 1'b1;
        if (prg_addr == LAST) begin
          busy_d  = 1'b0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (mar_in) mar_d = bus[ADDR_W-1:0];
        // A read owns the bus, so a simultaneous write is dropped.
        if (wr_en && !re_en) begin
          mem_we    = 1'b1;
          mem_waddr = mar;
          mem_wdata = bus;
        end
        if (prg_mode) begin
          state_d    = S_PROGRAM;
          prg_addr_d = '0;
          ready_d    = 1'b1;
          done_d     = 1'b0;
        end
      end

      S_PROGRAM: begin
        if (!prg_mode) begin
          state_d = S_RUN;
          ready_d = 1'b0;
        end else if (prg_valid && prg_ready) begin
          mem_we     = 1'b1;
          mem_wdata  = prg_data;
          prg_addr_d = prg_addr + 1'b1;
          if (prg_addr == LAST) begin
            ready_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (!prg_mode) begin
          done_d  = 1'b0;
          state_d = S_RUN;
        end
      end

      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= CLEAR_ON_RST ? S_CLEAR : S_RUN;
      mar       <= '0;
      prg_addr  <= '0;
      prg_ready <= 1'b0;
      prg_done  <= 1'b0;
      busy      <= CLEAR_ON_RST;
    end else begin
      state     <= state_d;
      mar       <= mar_d;
      prg_addr  <= prg_addr_d;
      prg_ready <= ready_d;
      prg_done  <= done_d;
      busy      <= busy_d;
    end
  end

  // NOTE: the storage array has no reset branch so it maps onto plain RAM;
  // clearing is done by the sweep instead.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_ram_prg.sv
// Directed bench for ram_prg: a reference array tracks every write and a
// queue of expected bus words is popped whenever the DUT drives a read.
module tb_ram_prg;

  logic       clk = 1'b0;
  logic       rst, mar_in, wr_en, re_en, prg_mode, prg_valid;
  logic [7:0] prg_data;
  logic [7:0] bus_drv;
  logic       bus_oe;
  wire  [7:0] bus;
  logic       prg_ready, prg_done, busy;
  logic [3:0] prg_addr, mar;

  logic       rst1, re_en1, prg_mode1, prg_valid1;
  logic [7:0] prg_data1;
  wire  [7:0] bus1;
  logic       prg_ready1, prg_done1, busy1;
  logic [3:0] prg_addr1, mar1;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] model [16];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  assign bus = bus_oe ? bus_drv : 8'bz;

  // Undriven bus levels read as 0xFF.
  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (bus[i]);
    pullup (bus1[i]);
  end

  ram_prg #(.DATA_W(8), .ADDR_W(4), .CLEAR_ON_RST(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .mar_in(mar_in), .wr_en(wr_en),
    .re_en(re_en), .prg_mode(prg_mode), .prg_valid(prg_valid),
    .prg_data(prg_data), .prg_ready(prg_ready), .prg_addr(prg_addr),
    .prg_done(prg_done), .busy(busy), .mar(mar)
  );

  ram_prg #(.DATA_W(8), .ADDR_W(4), .CLEAR_ON_RST(1'b0)) dut_keep (
    .clk(clk), .rst(rst1), .bus(bus1), .mar_in(1'b0), .wr_en(1'b0),
    .re_en(re_en1), .prg_mode(prg_mode1), .prg_valid(prg_valid1),
    .prg_data(prg_data1), .prg_ready(prg_ready1), .prg_addr(prg_addr1),
    .prg_done(prg_done1), .busy(busy1), .mar(mar1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mar(input logic [3:0] a);
    bus_drv = {4'h0, a};
    bus_oe  = 1'b1;
    mar_in  = 1'b1;
    step();
    mar_in  = 1'b0;
    bus_oe  = 1'b0;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [7:0] d);
    load_mar(a);
    bus_drv = d;
    bus_oe  = 1'b1;
    wr_en   = 1'b1;
    step();
    wr_en   = 1'b0;
    bus_oe  = 1'b0;
    model[a] = d;
  endtask

  task automatic read_word(input string tag, input logic [3:0] a);
    load_mar(a);
    re_en = 1'b1;
    exp_q.push_back(model[a]);
    #1;
    check(tag, bus, exp_q.pop_front());
    re_en = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      step();
    end
    check(tag, cnt, 16);
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
  endtask

  initial begin
    int k;
    int c;
    logic [3:0] ptr;

    rst = 1'b1; mar_in = 0; wr_en = 0; re_en = 0; prg_mode = 0; prg_valid = 0;
    prg_data = 0; bus_drv = 0; bus_oe = 0;
    rst1 = 1'b1; re_en1 = 0; prg_mode1 = 0; prg_valid1 = 0; prg_data1 = 0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    step();
    rst = 1'b0; rst1 = 1'b0;
    check("rst_busy", busy, 1);
    check("rst_mar", mar, 0);
    check("rst_ready", prg_ready, 0);
    check("rst_done", prg_done, 0);
    check("rst_keep_busy", busy1, 0);
    wait_clear("first_clear_len");

    // Fill every word with 0xFF, then reset and expect the sweep to zero it.
    prg_mode = 1'b1;
    step();
    prg_valid = 1'b1;
    prg_data  = 8'hFF;
    for (int i = 0; i < 16; i++) step();
    prg_valid = 1'b0;
    check("fill_done", prg_done, 1);
    prg_mode = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("sweep_addr0", prg_addr, 0);
    wait_clear("sweep_len");
    check("sweep_addr_wrap", prg_addr, 0);
    for (int i = 0; i < 16; i++) read_word("sweep_read", 4'(i));

    // Basic MAR load, write, same-cycle read and release of the bus.
    write_word(4'd3, 8'hA5);
    re_en = 1'b1;
    exp_q.push_back(model[3]);
    #1;
    check("rd_a5", bus, exp_q.pop_front());
    check("rd_mar", mar, 3);
    re_en = 1'b0;
    #1;
    check("bus_hiz", bus, 8'hFF);
    step();

    // MAR load and write in one cycle uses the old MAR.
    write_word(4'd7, 8'h11);
    load_mar(4'd2);
    bus_drv = 8'h07; bus_oe = 1'b1; mar_in = 1'b1; wr_en = 1'b1;
    step();
    bus_oe = 1'b0; mar_in = 1'b0; wr_en = 1'b0;
    model[2] = 8'h07;
    check("mar_after_load_write", mar, 7);
    re_en = 1'b1; wr_en = 1'b1;
    exp_q.push_back(model[7]);
    #1;
    check("rd_wr_bus", bus, exp_q.pop_front());
    step();
    re_en = 1'b0; wr_en = 1'b0;
    read_word("rd_wr_kept", 4'd7);
    read_word("old_mar_write", 4'd2);

    // Gapped streaming load of all sixteen words.
    prg_mode = 1'b1;
    step();
    check("prg_enter_ready", prg_ready, 1);
    check("prg_enter_addr", prg_addr, 0);
    k = 0; c = 0; ptr = 4'd0;
    while (k < 16 && c < 100) begin
      prg_valid = (c % 3) != 2;
      prg_data  = 8'(8'h10 + k);
      step();
      if (prg_valid) begin
        model[ptr] = prg_data;
        ptr++;
        k++;
      end
      check("prg_ptr", prg_addr, ptr);
      c++;
    end
    prg_valid = 1'b0;
    check("prg_words", k, 16);
    check("prg_done", prg_done, 1);
    check("prg_ready_low", prg_ready, 0);
    step();
    check("prg_done_held", prg_done, 1);
    prg_mode = 1'b0;
    step();
    check("prg_done_clear", prg_done, 0);
    for (int i = 0; i < 16; i++) read_word("prg_read", 4'(i));

    // Abort after five words, with a word offered in the abort cycle.
    prg_mode = 1'b1;
    step();
    prg_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      prg_data = 8'(8'h50 + i);
      model[i] = prg_data;
      step();
    end
    check("abort_ptr", prg_addr, 5);
    prg_mode = 1'b0;
    prg_data = 8'h99;
    step();
    prg_valid = 1'b0;
    check("abort_ready", prg_ready, 0);
    check("abort_done", prg_done, 0);
    for (int i = 0; i < 6; i++) read_word("abort_read", 4'(i));

    // Reset in the middle of programming.
    prg_mode = 1'b1;
    step();
    prg_valid = 1'b1;
    prg_data  = 8'h77;
    for (int i = 0; i < 9; i++) step();
    check("midprg_ptr", prg_addr, 9);
    rst = 1'b1;
    step();
    rst = 1'b0; prg_mode = 1'b0; prg_valid = 1'b0;
    check("midprg_busy", busy, 1);
    check("midprg_ready", prg_ready, 0);
    check("midprg_addr", prg_addr, 0);
    wait_clear("midprg_clear_len");
    read_word("midprg_read0", 4'd0);
    read_word("midprg_read8", 4'd8);

    // Build without sweep: reset keeps contents and goes straight to RUN.
    prg_mode1 = 1'b1;
    step();
    prg_valid1 = 1'b1;
    prg_data1  = 8'h3C;
    step();
    prg_valid1 = 1'b0;
    prg_mode1  = 1'b0;
    step();
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    check("keep_busy", busy1, 0);
    check("keep_mar", mar1, 0);
    re_en1 = 1'b1;
    exp_q.push_back(8'h3C);
    #1;
    check("keep_read", bus1, exp_q.pop_front());
    re_en1 = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_prg.md
Name: ram_prg

Overview:
Parametrised successor to the SAP-1 16x8 RAM. It provides a DATA_W x 2^ADDR_W register-file memory on the shared tri-state bus, with an integrated memory address register (MAR). It adds an optional clear-on-reset sweep and a valid/ready streaming programming loader with an auto-incrementing pointer. It sits on the CPU bus beside the accumulator, B register and output register, and is fed by the front-panel/test-bench program loader.

Parameters:
DATA_W, 8, bus and word width in bits
ADDR_W, 4, address width; DEPTH = 2^ADDR_W words
CLEAR_ON_RST, 1, 1 = zero every word after reset (sweep); 0 = skip sweep and keep contents

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
bus  inout  DATA_W  shared CPU bus
mar_in  input  1  load MAR from bus[ADDR_W-1:0]
wr_en  input  1  write bus into mem[MAR]
re_en  input  1  drive mem[MAR] onto bus
prg_mode  input  1  request programming mode
prg_valid  input  1  prg_data holds a word
prg_data  input  DATA_W  programming word
prg_ready  output  1  loader accepts a word this cycle
prg_addr  output  ADDR_W  pointer for the next programmed word
prg_done  output  1  all DEPTH words programmed
busy  output  1  clear sweep in progress
mar  output  ADDR_W  current MAR value (display/debug)

Behaviour:
- States: CLEAR, RUN, PROGRAM, DONE. All outputs are registered except bus.
- rst (sampled at posedge, any state, including mid-program):
  - mar=0, prg_addr=0, prg_ready=0, prg_done=0.
  - Next state is CLEAR with busy=1 when CLEAR_ON_RST=1, otherwise RUN with busy=0.
- CLEAR:
  - Writes 0 to mem[prg_addr], one word per cycle, incrementing prg_addr.
  - Takes exactly DEPTH cycles. After writing DEPTH-1: prg_addr wraps to 0, busy=0, next state RUN.
  - prg_mode, mar_in, wr_en and re_en are ignored; bus stays hi-Z.
- RUN:
  - mar_in: mar <= bus[ADDR_W-1:0] at posedge.
  - wr_en: mem[mar] <= bus at posedge, using the pre-edge mar when mar_in is also asserted.
  - re_en: bus = mem[mar], combinational (zero latency); otherwise bus is hi-Z.
  - re_en and wr_en together: the read drives the bus and the write is suppressed.
  - A write followed by a read of the same address in the next cycle returns the new data.
  - prg_mode=1 at posedge: next state PROGRAM, prg_addr=0, prg_ready=1, prg_done=0.
- PROGRAM:
  - prg_ready=1. On prg_valid&&prg_ready: mem[prg_addr] <= prg_data, prg_addr++.
  - prg_valid low: no write, pointer holds.
  - Transfer at prg_addr=DEPTH-1: prg_addr wraps to 0, prg_ready=0, prg_done=1, next state DONE.
  - prg_mode dropped: abort to RUN, prg_ready=0, words already written are kept, no write in that cycle even if prg_valid=1.
  - Bus-side controls are ignored; bus stays hi-Z.
- DONE:
  - prg_done=1 is held until prg_mode=0, then prg_done=0 and next state RUN.
  - Bus-side controls are ignored.
- Memory power-up contents are zero (simulation initialisation). mar is unaffected by programming.

Test Plan:
1. rst=1 for one cycle with CLEAR_ON_RST=1 and mem preloaded with 0xFF -> busy=1 for exactly 16 cycles, then RUN; reading addresses 0..15 returns 0x00 each.
2. RUN: bus=0x03 with mar_in; then bus=0xA5 with wr_en; then re_en -> bus reads 0xA5 in the same cycle as re_en and mar=3. With re_en=0 the bus is hi-Z.
3. Same cycle: mar_in=1, bus=0x07, wr_en=1 with prior mar=2 -> mem[2]=0x07 and mar=7. Then re_en&&wr_en with mem[7] holding 0x11 and driver off -> bus=0x11 and mem[7] unchanged.
4. prg_mode=1, stream 16 words 0x10..0x1F with prg_valid gapped every third cycle -> prg_addr steps only on accepted words; prg_done=1 after the 16th; RUN reads back 0x10..0x1F. Dropping prg_mode returns to RUN.
5. Programming abort: write 5 words, drop prg_mode while prg_valid=1 -> mem[0..4] programmed, mem[5] unchanged, state RUN, prg_ready=0.
6. rst during PROGRAM at prg_addr=9 -> next cycle busy=1, prg_ready=0, prg_addr=0. With CLEAR_ON_RST=0 (separate build), reset goes straight to RUN with contents retained.
